// File: rtl/ubit_decoder_pkg.sv
// Shared definitions for the unary-bitstream decoder.
//   state_t : decoder FSM state encoding (IDLE, RUN, DONE)
//   period(): stream period in cycles for a given binary word width,
//             2^(width-1)
package unary_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int period(input int width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/ubit_decoder_if.sv
// Handshake/data bundle between a bitstream source/consumer and ubit_decoder.
//   i_start   : request a new decode window
//   i_bit     : unary rate bitstream bit
//   i_ready   : consumer accepts o_data
//   o_busy    : decoder is counting a window
//   o_valid   : o_data holds a finished count
//   o_data    : count of ones in the window (WIDTH bits)
//   i_log_len : log2 of window length (only when UBIT_DECODER_EARLY_TERM_EN
//               is defined)
// master = source/consumer side, slave = decoder side.
interface ubit_decoder_if #(parameter int WIDTH = 16) ();
  logic             i_start;
  logic             i_bit;
  logic             i_ready;
  logic             o_busy;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
`ifdef UBIT_DECODER_EARLY_TERM_EN
  logic [$clog2(WIDTH)-1:0] i_log_len;

  modport master (output i_start, i_bit, i_ready, i_log_len,
                  input  o_busy, o_valid, o_data);
  modport slave  (input  i_start, i_bit, i_ready, i_log_len,
                  output o_busy, o_valid, o_data);
`else
  modport master (output i_start, i_bit, i_ready,
                  input  o_busy, o_valid, o_data);
  modport slave  (input  i_start, i_bit, i_ready,
                  output o_busy, o_valid, o_data);
`endif
endinterface

// File: rtl/ubit_decoder.sv
// Unary (rate-coded) bitstream decoder: counts the ones in a window of
// PERIOD = 2^(WIDTH-1) cycles and presents the count with a valid/ready
// handshake. A finished result can be handed off in the same cycle a new
// window starts, so windows can run back-to-back.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ubit_decoder_if.slave (i_start, i_bit, i_ready -> o_busy,
//           o_valid, o_data)
// Optional feature: define UBIT_DECODER_EARLY_TERM_EN to add bus.i_log_len,
// selecting a shorter window of 2^i_log_len cycles whose count is scaled
// back up to full-window units.
module ubit_decoder
  import unary_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  ubit_decoder_if.slave bus
);

  localparam int PERIOD = period(WIDTH);

  state_t           state;
  logic [WIDTH-2:0] cyc;
  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-2:0] last_cnt;
  logic [WIDTH-1:0] result;
  logic             accept;

  // Count including this cycle's bit; used both for accumulation and for the
  // final registered result so the last sample is never lost.
  assign sum = ones + WIDTH'(bus.i_bit);

  // A start is honoured from IDLE, or from DONE when the pending result is
  // taken in the same cycle.
  assign accept = bus.i_start &&
                  ((state == IDLE) || ((state == DONE) && bus.i_ready));

`ifdef UBIT_DECODER_EARLY_TERM_EN
  localparam int LW = $clog2(WIDTH);

  logic [LW-1:0] len;
  logic [LW-1:0] len_in;

  // Out-of-range lengths saturate to the full window.
  assign len_in = (int'(bus.i_log_len) > WIDTH - 1) ? LW'(WIDTH - 1)
                                                     : bus.i_log_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      len <= LW'(WIDTH - 1);
    else if (accept) len <= len_in;
  end

  assign last_cnt = (WIDTH-1)'((1 << len) - 1);
  // Short windows are rescaled so o_data is always in full-window units.
  assign result   = sum << (LW'(WIDTH - 1) - len);
`else
  assign last_cnt = (WIDTH-1)'(PERIOD - 1);
  assign result   = sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cyc         <= '0;
      ones        <= '0;
      bus.o_data  <= '0;
      bus.o_valid <= 1'b0;
      bus.o_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state       <= RUN;
            cyc         <= '0;
            ones        <= '0;
            bus.o_busy  <= 1'b1;
            bus.o_valid <= 1'b0;
          end else if ((state == DONE) && bus.i_ready) begin
            state       <= IDLE;
            bus.o_valid <= 1'b0;
          end
        end
        RUN: begin
          if (cyc == last_cnt) begin
            state       <= DONE;
            bus.o_data  <= result;
            bus.o_valid <= 1'b1;
            bus.o_busy  <= 1'b0;
          end else begin
            cyc  <= cyc + (WIDTH-1)'(1);
            ones <= sum;
          end
        end
        default: begin
          state       <= IDLE;
          bus.o_valid <= 1'b0;
          bus.o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ubit_decoder.sv
// Self-checking bench for ubit_decoder at WIDTH=4 (PERIOD=8): a table of
// windows (bit pattern, expected count, consumer delay, start pulses during
// RUN, back-to-back chaining), randomized windows checked against a simple
// ones-count model, and hand-written reset and early-termination sequences.
module tb_ubit_decoder;

  localparam int W = 4;
  localparam int P = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ubit_decoder_if #(.WIDTH(W)) bus ();

  ubit_decoder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks    = 0;
  int errors    = 0;
  int last_data = 0;

  typedef struct {
    logic [7:0] bits;
    int         exp;
    int         rdly;
    bit         pulses;
    bit         b2b;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: number of ones in an 8-bit window.
  function automatic int model_count(input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < P; i++) if (b[i]) n++;
    return n;
  endfunction

  // Called in the cycle where start is already being requested (cycle 0).
  // Drives bits MSB first in cycles 1..P, then checks the result in P+1.
  task automatic feed(input logic [7:0] bits, input int exp, input bit pulses);
    for (int c = 0; c < P; c++) begin
      @(posedge clk); #1;
      bus.i_start = pulses ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.i_ready = 1'($urandom_range(0, 1));
      chk("run_busy",  32'(bus.o_busy), 1);
      chk("run_valid", 32'(bus.o_valid), 0);
      chk("run_data_hold", 32'(bus.o_data), last_data);
      bus.i_bit = bits[7-c];
    end
    @(posedge clk); #1;
    bus.i_bit   = 1'b0;
    bus.i_start = 1'b0;
    bus.i_ready = 1'b0;
    chk("done_valid", 32'(bus.o_valid), 1);
    chk("done_data",  32'(bus.o_data), exp);
    chk("done_busy",  32'(bus.o_busy), 0);
    last_data = exp;
  endtask

  // Holds the consumer off for rdly cycles, then handshakes. With nxt set a
  // new window starts in the handshake cycle and the caller continues with
  // feed() directly.
  task automatic release_res(input int rdly, input bit nxt);
    repeat (rdly) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.o_valid), 1);
      chk("hold_data",  32'(bus.o_data), last_data);
    end
    bus.i_ready = 1'b1;
    bus.i_start = nxt;
    if (!nxt) begin
      @(posedge clk); #1;
      bus.i_ready = 1'b0;
      chk("idle_valid", 32'(bus.o_valid), 0);
      chk("idle_busy",  32'(bus.o_busy), 0);
      chk("idle_data",  32'(bus.o_data), last_data);
    end
  endtask

  initial begin
    bit         b2b;
    bit         nb;
    logic [7:0] rb;

    bus.i_start = 1'b0;
    bus.i_bit   = 1'b0;
    bus.i_ready = 1'b0;
`ifdef UBIT_DECODER_EARLY_TERM_EN
    bus.i_log_len = 2'd3;
`endif

    tv[0] = '{8'hFF,       8, 0, 1'b0, 1'b0};
    tv[1] = '{8'b10110010, 4, 5, 1'b0, 1'b0};
    tv[2] = '{8'h00,       0, 1, 1'b0, 1'b0};
    tv[3] = '{8'hFF,       8, 2, 1'b0, 1'b1};
    tv[4] = '{8'h00,       0, 0, 1'b0, 1'b0};
    tv[5] = '{8'b01100101, 4, 0, 1'b1, 1'b0};
    tv[6] = '{8'h80,       1, 3, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  32'(bus.o_busy), 0);
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_data",  32'(bus.o_data), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven windows
    b2b = 1'b0;
    foreach (tv[i]) begin
      if (!b2b) bus.i_start = 1'b1;
      feed(tv[i].bits, tv[i].exp, tv[i].pulses);
      release_res(tv[i].rdly, tv[i].b2b);
      b2b = tv[i].b2b;
    end

    // Reset in the middle of a window of all ones
    bus.i_start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      bus.i_bit   = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy",  32'(bus.o_busy), 0);
    chk("midrun_rst_valid", 32'(bus.o_valid), 0);
    chk("midrun_rst_data",  32'(bus.o_data), 0);
    last_data = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", 32'(bus.o_valid), 0);
      chk("post_rst_busy",  32'(bus.o_busy), 0);
    end
    bus.i_bit   = 1'b0;
    bus.i_start = 1'b1;
    feed(8'hFF, 8, 1'b0);
    release_res(0, 1'b0);

    // Reset while a result is pending
    bus.i_start = 1'b1;
    feed(8'b00010111, 4, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("done_rst_valid", 32'(bus.o_valid), 0);
    chk("done_rst_data",  32'(bus.o_data), 0);
    last_data = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("done_rst_no_valid", 32'(bus.o_valid), 0);
    end

    // Randomized windows with random consumer delay and chaining
    b2b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom);
      nb = (i == 19) ? 1'b0 : 1'($urandom_range(0, 1));
      if (!b2b) bus.i_start = 1'b1;
      feed(rb, model_count(rb), 1'b1);
      release_res(int'($urandom_range(0, 3)), nb);
      b2b = nb;
    end

`ifdef UBIT_DECODER_EARLY_TERM_EN
    // Four-cycle window, bits 1101 -> 3 ones scaled by 2
    bus.i_log_len = 2'd2;
    bus.i_start   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus.i_log_len = 2'd3;
      bus.i_start   = 1'b0;
      chk("et_busy",  32'(bus.o_busy), 1);
      chk("et_valid", 32'(bus.o_valid), 0);
      bus.i_bit = (c == 2) ? 1'b0 : 1'b1;
    end
    @(posedge clk); #1;
    bus.i_bit = 1'b0;
    chk("et_done_valid", 32'(bus.o_valid), 1);
    chk("et_done_data",  32'(bus.o_data), 6);
    last_data = 6;
    release_res(0, 1'b0);
    bus.i_start = 1'b1;
    feed(8'hFF, 8, 1'b0);
    release_res(0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ubit_decoder.md
UBIT_DECODER -- requirements
Module: ubit_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, binary word width; stream period PERIOD = 2^(WIDTH-1) cycles.
REQ-002 SHALL have port clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_start  input  1  request a new decode window.
REQ-005 SHALL have port i_bit  input  1  unary rate bitstream bit.
REQ-006 SHALL have port i_ready  input  1  consumer accepts o_data.
REQ-007 SHALL have port o_busy  output  1  high in RUN.
REQ-008 SHALL have port o_valid  output  1  result available (high in DONE).
REQ-009 SHALL have port o_data  output  WIDTH  count of ones in the window.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE.
REQ-011 IDLE: i_start=1 -> RUN next cycle, cycle counter and ones counter cleared.
REQ-012 RUN: i_bit sampled every cycle; ones counter += i_bit; cycle counter (WIDTH-1 bits) increments.
REQ-013 RUN lasts exactly PERIOD cycles; on the cycle the counter equals PERIOD-1, the final sum including that cycle's i_bit is registered to o_data and the state becomes DONE.
REQ-014 Latency: i_start at cycle 0 -> bits sampled cycles 1..PERIOD -> o_valid high from cycle PERIOD+1.
REQ-015 Ones counter SHALL be WIDTH bits; all-ones stream yields o_data = PERIOD (no overflow); all-zeros yields 0.
REQ-016 i_start during RUN SHALL be ignored; i_ready outside DONE SHALL be ignored.
REQ-017 DONE: o_valid and o_data held stable until i_ready=1; handshake cycle -> IDLE.
REQ-018 DONE with i_ready=1 and i_start=1 in the same cycle -> RUN directly, counters cleared (back-to-back windows, no IDLE bubble).
REQ-019 o_data SHALL change only on RUN->DONE transition or reset.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, counters 0, o_data 0, o_valid 0, o_busy 0.
REQ-021 Reset mid-RUN or mid-DONE SHALL discard the partial/pending result; no o_valid after release until a new full window.

Configuration
REQ-022 Macro UBIT_DECODER_EARLY_TERM_EN defined: adds input i_log_len (clog2(WIDTH) bits, valid 0..WIDTH-1), captured at accepted i_start; RUN lasts 2^i_log_len cycles; o_data = ones << (WIDTH-1-i_log_len), same scale as full window.
REQ-023 Values of i_log_len > WIDTH-1 SHALL be treated as WIDTH-1.
REQ-024 Macro undefined: port i_log_len absent; window fixed at PERIOD.

Structure
REQ-025 Shared package unary_pkg SHALL hold the state enum typedef and a PERIOD-from-WIDTH constant function.
REQ-026 Single flat module; no sub-module required (FSM, two counters, output register).

Verification (WIDTH=4, PERIOD=8)
REQ-027 i_start, i_bit=1 for 8 cycles, i_ready=1 -> o_valid at cycle 9, o_data=8.
REQ-028 i_start, bit pattern 10110010 -> o_data=4; i_ready=0 for 5 cycles -> o_valid/o_data held, then IDLE after handshake.
REQ-029 In DONE assert i_ready and i_start together, next stream all-zeros -> first o_data delivered, no IDLE cycle, second o_data=0.
REQ-030 rst_n low at RUN cycle 4 of stream 11111111 -> all outputs 0, no o_valid; fresh window then yields 8.
REQ-031 i_start pulses during RUN -> ignored, window still exactly 8 cycles.
REQ-032 With UBIT_DECODER_EARLY_TERM_EN, i_log_len=2, bits 1101 -> o_valid at cycle 5, o_data=3<<1=6.
